// File: rtl/fdivider_pkg.sv
// Shared FPU definitions for the single-precision divider: FSM state codes,
// rounding-mode encodings, exception flag bit positions and IEEE-754 constants.
package fdivider_pkg;

    // Divider FSM state codes
    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_UNPACK  = 4'd1;
    localparam logic [3:0] ST_SPECIAL = 4'd2;
    localparam logic [3:0] ST_NORM_A  = 4'd3;
    localparam logic [3:0] ST_NORM_B  = 4'd4;
    localparam logic [3:0] ST_DIV_0   = 4'd5;
    localparam logic [3:0] ST_DIV_1   = 4'd6;
    localparam logic [3:0] ST_DIV_2   = 4'd7;
    localparam logic [3:0] ST_NORM_1  = 4'd8;
    localparam logic [3:0] ST_NORM_2  = 4'd9;
    localparam logic [3:0] ST_PACK    = 4'd10;
    localparam logic [3:0] ST_PUT_Z   = 4'd11;

    // Rounding modes
    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    // Exception flag bit positions within flag[4:0] = {NV,DZ,OF,UF,NX}
    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    // IEEE-754 single-precision constants
    localparam logic [31:0]        QNAN = 32'h7FC00000;
    localparam logic signed [9:0]  BIAS = 10'sd127;
    localparam logic signed [9:0]  EMIN = -10'sd126;
    localparam logic signed [9:0]  EMAX = 10'sd127;

    // Operand classification helpers
    function automatic logic is_nan(input logic [31:0] x);
        return (&x[30:23]) && (|x[22:0]);
    endfunction

    function automatic logic is_snan(input logic [31:0] x);
        return is_nan(x) && !x[22];
    endfunction

    function automatic logic is_inf(input logic [31:0] x);
        return (&x[30:23]) && !(|x[22:0]);
    endfunction

    function automatic logic is_zero(input logic [31:0] x);
        return !(|x[30:0]);
    endfunction

endpackage

// File: rtl/fdivider_round.sv
// Shared rounding unit: takes a normalised (or denormalised at EMIN) mantissa
// with guard/round/sticky and produces the packed single-precision result and
// the OF/UF/NX exception bits. Purely combinational.
module fdivider_round
    import fdivider_pkg::*;
(
    input  logic              sign,
    input  logic signed [9:0] exp_in,
    input  logic [23:0]       man,
    input  logic              guard,
    input  logic              round_bit,
    input  logic              sticky,
    input  logic [2:0]        rm,
    output logic [31:0]       z,
    output logic              of,
    output logic              uf,
    output logic              nx
);

    logic              inexact;
    logic              round_up;
    logic              to_inf;
    logic              tiny;
    logic [24:0]       sum;
    logic [23:0]       m_fin;
    logic signed [9:0] e_fin;
    logic [7:0]        exp_field;

    // Rounding decision and overflow direction for the selected mode
    always_comb begin
        inexact  = guard | round_bit | sticky;
        round_up = 1'b0;
        to_inf   = 1'b1;
        case (rm)
            RM_RTZ: begin
                round_up = 1'b0;
                to_inf   = 1'b0;
            end
            RM_RDN: begin
                round_up = sign & inexact;
                to_inf   = sign;
            end
            RM_RUP: begin
                round_up = ~sign & inexact;
                to_inf   = ~sign;
            end
            RM_RMM: begin
                round_up = guard;
                to_inf   = 1'b1;
            end
            default: begin
                // RNE; unused encodings fall back to it
                round_up = guard & (round_bit | sticky | man[0]);
                to_inf   = 1'b1;
            end
        endcase
    end

    // Increment, renormalise on carry-out, then pack or saturate
    always_comb begin
        sum = {1'b0, man} + {24'd0, round_up};
        if (sum[24]) begin
            m_fin = sum[24:1];
            e_fin = exp_in + 10'sd1;
        end else begin
            m_fin = sum[23:0];
            e_fin = exp_in;
        end
        // A subnormal that rounds up into bit 23 becomes the smallest normal
        exp_field = m_fin[23] ? 8'(e_fin + BIAS) : 8'd0;
        tiny      = ~man[23];
        of        = (e_fin > EMAX);
        nx        = inexact | of;
        uf        = tiny & inexact;
        if (of) begin
            z = to_inf ? {sign, 8'hFF, 23'd0} : {sign, 8'hFE, 23'h7FFFFF};
        end else begin
            z = {sign, exp_field, m_fin[22:0]};
        end
    end

endmodule

// File: rtl/fdivider.sv
// Multi-cycle IEEE-754 single-precision divider. Special operands are resolved
// early; ordinary operands go through normalisation, a 27-step restoring
// divide, post-normalisation and the shared rounding unit.
//
// Handshake: input_stb is a request sampled only while busy=0 (IDLE); on that
// edge the operands and rounding mode are captured and busy rises on the next
// cycle. Requests while busy=1 are dropped, not queued. Completion is a single
// cycle pulse on output_z_stb with output_z/flag valid alongside it; output_z
// and flag then hold until the next completion or reset.
module fdivider
    import fdivider_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_a,
    input  logic [31:0] input_b,
    input  logic [2:0]  rm,
    input  logic        input_stb,
    output logic        busy,
    output logic [31:0] output_z,
    output logic        output_z_stb,
    output logic [4:0]  flag
);

    logic [3:0]        state;

    // Captured request
    logic [31:0]       a_r;
    logic [31:0]       b_r;
    logic [2:0]        rm_r;

    // Unpacked operands (mantissa includes the hidden bit)
    logic [23:0]       a_m;
    logic [23:0]       b_m;
    logic signed [9:0] a_e;
    logic signed [9:0] b_e;

    // Quotient datapath
    logic              z_s;
    logic signed [9:0] z_e;
    logic [23:0]       z_m;
    logic              guard;
    logic              round_bit;
    logic              sticky;
    logic [26:0]       q;
    logic [24:0]       rem;
    logic [24:0]       rem_diff;
    logic [4:0]        count;

    // Result staged for PUT_Z
    logic [31:0]       z_r;
    logic [4:0]        flag_r;

    // Special-operand resolution
    logic              op_sign;
    logic              spec_hit;
    logic [31:0]       spec_z;
    logic [4:0]        spec_flag;

    // Underflow denormalisation
    logic signed [9:0] deficit;
    logic [4:0]        sh;
    logic [26:0]       wide;
    logic [26:0]       shifted;
    logic [26:0]       lost_mask;
    logic              lost;

    // Rounding unit outputs
    logic [31:0]       round_z;
    logic              round_of;
    logic              round_uf;
    logic              round_nx;
    logic [4:0]        pack_flag;

    assign busy     = (state != ST_IDLE);
    assign op_sign  = a_r[31] ^ b_r[31];
    assign rem_diff = rem - {1'b0, b_m};

    // Classify the captured operands; spec_hit means no division is needed
    always_comb begin
        spec_hit  = 1'b1;
        spec_z    = QNAN;
        spec_flag = 5'd0;
        if (is_nan(a_r) || is_nan(b_r)) begin
            spec_flag[FLAG_NV] = is_snan(a_r) || is_snan(b_r);
        end else if ((is_inf(a_r) && is_inf(b_r)) || (is_zero(a_r) && is_zero(b_r))) begin
            spec_flag[FLAG_NV] = 1'b1;
        end else if (is_inf(a_r)) begin
            spec_z = {op_sign, 8'hFF, 23'd0};
        end else if (is_inf(b_r)) begin
            spec_z = {op_sign, 31'd0};
        end else if (is_zero(b_r)) begin
            spec_z             = {op_sign, 8'hFF, 23'd0};
            spec_flag[FLAG_DZ] = 1'b1;
        end else if (is_zero(a_r)) begin
            spec_z = {op_sign, 31'd0};
        end else begin
            spec_hit = 1'b0;
        end
    end

    // Right-shift amount to bring a tiny result up to EMIN in a single step;
    // anything beyond 27 places only contributes to sticky
    always_comb begin
        deficit = EMIN - z_e;
        sh      = 5'd0;
        if (z_e < EMIN) begin
            sh = (deficit > 10'sd27) ? 5'd27 : deficit[4:0];
        end
        wide      = {z_m, guard, round_bit, sticky};
        shifted   = wide >> sh;
        lost_mask = (27'd1 << sh) - 27'd1;
        lost      = |(wide & lost_mask);
    end

    // Assemble the exception flags produced by rounding
    always_comb begin
        pack_flag          = 5'd0;
        pack_flag[FLAG_OF] = round_of;
        pack_flag[FLAG_UF] = round_uf;
        pack_flag[FLAG_NX] = round_nx;
    end

    fdivider_round u_round (
        .sign      (z_s),
        .exp_in    (z_e),
        .man       (z_m),
        .guard     (guard),
        .round_bit (round_bit),
        .sticky    (sticky),
        .rm        (rm_r),
        .z         (round_z),
        .of        (round_of),
        .uf        (round_uf),
        .nx        (round_nx)
    );

    // Divider FSM and datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            a_r       <= 32'd0;
            b_r       <= 32'd0;
            rm_r      <= RM_RNE;
            a_m       <= 24'd0;
            b_m       <= 24'd0;
            a_e       <= 10'sd0;
            b_e       <= 10'sd0;
            z_s       <= 1'b0;
            z_e       <= 10'sd0;
            z_m       <= 24'd0;
            guard     <= 1'b0;
            round_bit <= 1'b0;
            sticky    <= 1'b0;
            q         <= 27'd0;
            rem       <= 25'd0;
            count     <= 5'd0;
            z_r       <= 32'd0;
            flag_r    <= 5'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (input_stb) begin
                        a_r   <= input_a;
                        b_r   <= input_b;
                        rm_r  <= rm;
                        state <= ST_UNPACK;
                    end
                end

                ST_UNPACK: begin
                    // Subnormals keep exponent EMIN with a clear hidden bit
                    if (a_r[30:23] == 8'd0) begin
                        a_e <= EMIN;
                        a_m <= {1'b0, a_r[22:0]};
                    end else begin
                        a_e <= $signed({2'b00, a_r[30:23]}) - BIAS;
                        a_m <= {1'b1, a_r[22:0]};
                    end
                    if (b_r[30:23] == 8'd0) begin
                        b_e <= EMIN;
                        b_m <= {1'b0, b_r[22:0]};
                    end else begin
                        b_e <= $signed({2'b00, b_r[30:23]}) - BIAS;
                        b_m <= {1'b1, b_r[22:0]};
                    end
                    state <= ST_SPECIAL;
                end

                ST_SPECIAL: begin
                    if (spec_hit) begin
                        z_r    <= spec_z;
                        flag_r <= spec_flag;
                        state  <= ST_PUT_Z;
                    end else begin
                        state <= ST_NORM_A;
                    end
                end

                ST_NORM_A: begin
                    if (a_m[23]) begin
                        state <= ST_NORM_B;
                    end else begin
                        a_m <= a_m << 1;
                        a_e <= a_e - 10'sd1;
                    end
                end

                ST_NORM_B: begin
                    if (b_m[23]) begin
                        state <= ST_DIV_0;
                    end else begin
                        b_m <= b_m << 1;
                        b_e <= b_e - 10'sd1;
                    end
                end

                ST_DIV_0: begin
                    z_s   <= op_sign;
                    z_e   <= a_e - b_e;
                    q     <= 27'd0;
                    count <= 5'd0;
                    rem   <= {1'b0, a_m};
                    state <= ST_DIV_1;
                end

                ST_DIV_1: begin
                    // Remainder stays below 2*b_m, so 25 bits never overflow
                    if (rem >= {1'b0, b_m}) begin
                        q   <= {q[25:0], 1'b1};
                        rem <= rem_diff << 1;
                    end else begin
                        q   <= {q[25:0], 1'b0};
                        rem <= rem << 1;
                    end
                    count <= count + 5'd1;
                    if (count == 5'd26) begin
                        state <= ST_DIV_2;
                    end
                end

                ST_DIV_2: begin
                    z_m       <= q[26:3];
                    guard     <= q[2];
                    round_bit <= q[1];
                    sticky    <= q[0] | (rem != 25'd0);
                    state     <= ST_NORM_1;
                end

                ST_NORM_1: begin
                    // The round position after this shift is already in sticky
                    if (!z_m[23]) begin
                        z_m       <= {z_m[22:0], guard};
                        guard     <= round_bit;
                        round_bit <= 1'b0;
                        z_e       <= z_e - 10'sd1;
                    end else begin
                        state <= ST_NORM_2;
                    end
                end

                ST_NORM_2: begin
                    if (z_e < EMIN) begin
                        z_m       <= shifted[26:3];
                        guard     <= shifted[2];
                        round_bit <= shifted[1];
                        sticky    <= shifted[0] | lost;
                        z_e       <= EMIN;
                    end
                    state <= ST_PACK;
                end

                ST_PACK: begin
                    z_r    <= round_z;
                    flag_r <= pack_flag;
                    state  <= ST_PUT_Z;
                end

                ST_PUT_Z: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Result registers and one-cycle completion strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            output_z     <= 32'd0;
            flag         <= 5'd0;
            output_z_stb <= 1'b0;
        end else begin
            output_z_stb <= (state == ST_PUT_Z);
            if (state == ST_PUT_Z) begin
                output_z <= z_r;
                flag     <= flag_r;
            end
        end
    end

endmodule

// File: doc/fdivider.md
FDIVIDER -- requirements
Module: fdivider

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port input_a, input, 32 bits: IEEE-754 single-precision dividend.
REQ-004 SHALL have port input_b, input, 32 bits: IEEE-754 single-precision divisor.
REQ-005 SHALL have port rm, input, 3 bits: rounding mode (000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM).
REQ-006 SHALL have port input_stb, input, 1 bit: operation request, sampled only in IDLE.
REQ-007 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-008 SHALL have port output_z, output, 32 bits: quotient, held until the next completion.
REQ-009 SHALL have port output_z_stb, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have port flag, output, 5 bits: {NV,DZ,OF,UF,NX}, valid with output_z.

Function
REQ-011 SHALL, on input_stb=1 in IDLE, capture input_a, input_b and rm into internal registers; later input changes are ignored.
REQ-012 SHALL ignore input_stb while busy=1; no queuing.
REQ-013 SHALL implement states IDLE, UNPACK, SPECIAL, NORM_A, NORM_B, DIV_0, DIV_1, DIV_2, NORM_1, NORM_2, PACK, PUT_Z, with PUT_Z returning to IDLE.
REQ-014 SHALL, in SPECIAL, resolve special operands directly to PUT_Z:
- NaN operand -> 0x7FC00000; NV set only for sNaN.
- 0/0 or inf/inf -> 0x7FC00000 with NV.
- inf/finite -> signed inf.
- finite/inf -> signed zero.
- finite nonzero/0 -> signed inf with DZ.
- 0/nonzero -> signed zero.
REQ-015 SHALL assert output_z_stb exactly 3 cycles after the accepting edge for SPECIAL-resolved operations.
REQ-016 SHALL treat subnormal operands as exponent -126 with hidden bit 0, then left-normalise in NORM_A/NORM_B one bit per cycle, decrementing the exponent.
REQ-017 SHALL compute z_s = a_s^b_s and z_e = a_e-b_e (10-bit signed) in DIV_0, and clear the quotient and 5-bit iteration counter.
REQ-018 SHALL perform restoring division in DIV_1, one quotient bit per cycle for exactly 27 cycles, producing q[26:0] (24 mantissa + guard + round + 1 extra).
REQ-019 SHALL, in DIV_2, set z_m=q[26:3] or the shifted equivalent, guard, round_bit, and sticky = (q extra bit | remainder != 0).
REQ-020 SHALL, in NORM_1, shift left while z_m[23]=0, decrementing z_e; at most 1 shift for normalised inputs.
REQ-021 SHALL, in NORM_2, shift right while z_e < -126, incrementing z_e and accumulating sticky.
REQ-022 SHALL, in PACK, apply rm via the shared rounding unit; exponent field 0 if the rounded result is subnormal.
REQ-023 SHALL, on PACK overflow (rounded exponent > 127), produce signed inf for RNE/RMM and for RUP(+)/RDN(-), else signed max-finite 0x7F7FFFFF|sign; OF and NX set.
REQ-024 SHALL set NX when any of guard/round/sticky is nonzero, and set UF when the result is tiny before rounding and NX.
REQ-025 SHALL, in PUT_Z, register output_z and flag and pulse output_z_stb for exactly one cycle.
REQ-026 SHALL complete normal-operand operations within 40 cycles of acceptance; subnormal inputs add at most 23 cycles each.

Reset
REQ-027 SHALL, when rst=1 at a clock edge, force state to IDLE, busy=0, output_z_stb=0, output_z=0 and flag=0, overriding any in-flight operation.
REQ-028 SHALL NOT, after a mid-operation reset, emit a strobe for the aborted operation; the next input_stb is accepted immediately.

Structure
REQ-029 SHALL take the state enum, rounding-mode encodings, flag bit positions, QNAN constant 0x7FC00000 and bias 127 from the shared FPU package.
REQ-030 SHALL instantiate the existing rounding sub-module for rounding and SHALL NOT duplicate its logic; the divider core is otherwise a single module.

Verification
REQ-031 SHALL cover 0x40C00000/0x40000000, RNE -> 0x40400000, flag 00000.
REQ-032 SHALL cover 0x3F800000/0x40400000 -> RNE 0x3EAAAAAB or RTZ 0x3EAAAAAA, both flag 00001.
REQ-033 SHALL cover 0x3F800000/0x00000000 -> 0x7F800000, flag 01000; 0/0 -> 0x7FC00000, flag 10000 (3-cycle latency).
REQ-034 SHALL cover 0x7F7FFFFF/0x3F000000 -> RNE 0x7F800000, flag 00101; RTZ 0x7F7FFFFF, flag 00101.
REQ-035 SHALL cover 0x00800000/0x40000000 -> 0x00400000, flag 00000; and 0x00000001/0x40000000 RNE -> 0x00000000, flag 00011.
REQ-036 SHALL cover rst pulsed during DIV_1 -> no strobe, busy=0 next cycle; immediate new 6.0/2.0 -> 0x40400000.
